// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encodings, frame constant and ASCII case folding
package uart_pkg;
  localparam int UART_FRAME_BITS = 10;
  typedef enum logic [1:0] {SEQ_IDLE, SEQ_LOAD, SEQ_SEND} seq_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  function automatic logic [7:0] to_upper(input logic [7:0] b);
    return (b >= 8'h61 && b <= 8'h7a) ? b - 8'h20 : b;
  endfunction
endpackage

// File: rtl/uart_tx_core.sv
// uart_tx_core: 8N1 serialiser that accepts the next byte in the final stop-bit cycle for gapless frames
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int BIT_DIV = 16
)(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       ready,
  output logic       done
);
  localparam int CW = $clog2(BIT_DIV);
  localparam logic [CW-1:0] LAST = CW'(BIT_DIV - 1);
  localparam logic [2:0] LAST_BIT = 3'(UART_FRAME_BITS - 3);
  tx_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] bit_idx, bit_idx_n;
  logic [7:0] shreg, shreg_n;
  logic last, accept;
  always_ff @(posedge clk)
    if (!rst_n) begin
      state   <= TX_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      shreg   <= shreg_n;
    end
  // done fires one cycle early so the caller's load cycle overlaps the last stop cycle
  always_comb begin
    last      = cnt == LAST;
    accept    = start && (state == TX_IDLE || (state == TX_STOP && last));
    state_n   = state;
    cnt_n     = (state == TX_IDLE || last) ? '0 : cnt + 1'b1;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    case (state)
      TX_IDLE: if (accept) begin
        state_n = TX_START;
        shreg_n = data;
      end
      TX_START: if (last) begin
        state_n   = TX_DATA;
        bit_idx_n = '0;
      end
      TX_DATA: if (last) begin
        shreg_n   = shreg >> 1;
        bit_idx_n = bit_idx + 1'b1;
        state_n   = bit_idx == LAST_BIT ? TX_STOP : TX_DATA;
      end
      TX_STOP: if (last) begin
        state_n = accept ? TX_START : TX_IDLE;
        shreg_n = accept ? data : shreg;
      end
      default: state_n = TX_IDLE;
    endcase
    tx    = state == TX_START ? 1'b0 : state == TX_DATA ? shreg[0] : 1'b1;
    ready = state == TX_IDLE;
    done  = state == TX_STOP && cnt == CW'(BIT_DIV - 2);
  end
endmodule

// File: rtl/uart_pattern_responder.sv
// uart_pattern_responder: detects a byte pattern in the rx stream and answers with a fixed 8N1 reply
module uart_pattern_responder
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD = 9600,
  parameter int PAT_LEN = 5,
  parameter logic [PAT_LEN*8-1:0] PATTERN = "MARCO",
  parameter int REP_LEN = 4,
  parameter logic [REP_LEN*8-1:0] REPLY = "POLO",
  parameter int COUNT_W = 8
)(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         rx_byte,
  input  logic               rx_valid,
  input  logic               case_fold,
  output logic               tx,
  output logic               busy,
  output logic               match_pulse,
  output logic               missed,
  output logic [COUNT_W-1:0] match_count
);
  localparam int BIT_DIV = CLK_HZ / BAUD;
  localparam int PW = PAT_LEN * 8;
  localparam int FW = $clog2(PAT_LEN + 1);
  localparam int IW = $clog2(REP_LEN + 1);
  logic [PW-1:0] win, pat_up;
  logic [FW-1:0] fill;
  logic shifted, fold_q, start, done, ready, last_byte;
  logic [7:0] rep_byte;
  logic [IW-1:0] idx, idx_n;
  seq_state_t seq, seq_n;
  for (genvar g = 0; g < PAT_LEN; g++) begin : g_fold
    assign pat_up[g*8 +: 8] = to_upper(PATTERN[g*8 +: 8]);
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      win         <= '0;
      fill        <= '0;
      shifted     <= 1'b0;
      fold_q      <= 1'b0;
      match_count <= '0;
      seq         <= SEQ_IDLE;
      idx         <= '0;
    end else begin
      shifted <= rx_valid;
      if (rx_valid) begin
        win    <= PW'({win, case_fold ? to_upper(rx_byte) : rx_byte});
        fold_q <= case_fold;
        if (fill != FW'(PAT_LEN)) fill <= fill + 1'b1;
      end
      if (match_pulse && match_count != '1) match_count <= match_count + 1'b1;
      seq <= seq_n;
      idx <= idx_n;
    end
  // busy spans the core's final stop cycle, so a hit there is reported as missed
  always_comb begin
    busy        = seq != SEQ_IDLE || !ready;
    match_pulse = shifted && fill == FW'(PAT_LEN) && win == (fold_q ? pat_up : PATTERN);
    missed      = match_pulse && busy;
    start       = seq == SEQ_LOAD;
    rep_byte    = REPLY[8*(REP_LEN-1-int'(idx)) +: 8];
    last_byte   = idx == IW'(REP_LEN - 1);
    seq_n       = seq;
    idx_n       = idx;
    if (seq == SEQ_IDLE && match_pulse && !busy) begin
      seq_n = SEQ_LOAD;
      idx_n = '0;
    end
    if (seq == SEQ_LOAD) seq_n = SEQ_SEND;
    if (seq == SEQ_SEND && done) begin
      seq_n = last_byte ? SEQ_IDLE : SEQ_LOAD;
      idx_n = last_byte ? '0 : idx + 1'b1;
    end
  end
  uart_tx_core #(.BIT_DIV(BIT_DIV)) u_tx (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .data  (rep_byte),
    .tx    (tx),
    .ready (ready),
    .done  (done)
  );
endmodule

// File: tb/tb_uart_pattern_responder.sv
// tb_uart_pattern_responder: vector tables, corner sequences and a cycle-level reference model
module tb_uart_pattern_responder;
  localparam int BD = 16, PL = 5, RL = 4, RLEN = RL * 10 * BD;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [7:0] rx_byte = 8'h0, b_byte = 8'h0;
  logic rx_valid = 1'b0, case_fold = 1'b0, b_valid = 1'b0;
  logic tx, busy, match_pulse, missed;
  logic [7:0] match_count;
  logic tx1, busy1, mp1, ms1;
  logic [7:0] mc1;
  logic tx2, busy2, mp2, ms2;
  logic [1:0] mc2;
  int checks = 0, errors = 0, cyc = 0;
  always #5 clk = ~clk;

  uart_pattern_responder #(.CLK_HZ(16), .BAUD(1)) dut (
    .clk(clk), .rst_n(rst_n), .rx_byte(rx_byte), .rx_valid(rx_valid), .case_fold(case_fold),
    .tx(tx), .busy(busy), .match_pulse(match_pulse), .missed(missed), .match_count(match_count));
  uart_pattern_responder #(.CLK_HZ(16), .BAUD(1), .PAT_LEN(2), .PATTERN("AA"), .REP_LEN(1), .REPLY("Z")) dut_aa (
    .clk(clk), .rst_n(rst_n), .rx_byte(b_byte), .rx_valid(b_valid), .case_fold(1'b0),
    .tx(tx1), .busy(busy1), .match_pulse(mp1), .missed(ms1), .match_count(mc1));
  uart_pattern_responder #(.CLK_HZ(16), .BAUD(1), .COUNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .rx_byte(b_byte), .rx_valid(b_valid), .case_fold(1'b0),
    .tx(tx2), .busy(busy2), .match_pulse(mp2), .missed(ms2), .match_count(mc2));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference model: byte history, reply start cycle and frame arithmetic
  string PAT = "MARCO", REP = "POLO";
  logic [7:0] m_q[$];
  int rep_t = -100000, m_cnt = 0;
  logic e_pulse = 1'b0, e_missed = 1'b0, e_busy = 1'b0, e_tx = 1'b1, m_en = 1'b0;
  function automatic logic [7:0] up(input logic [7:0] b);
    return (b >= "a" && b <= "z") ? b - 8'd32 : b;
  endfunction
  function automatic logic tx_at(input int n);
    logic [7:0] c;
    int bit_no;
    if (n < 0 || n >= RLEN) return 1'b1;
    c = REP[n / (10 * BD)];
    bit_no = (n / BD) % 10;
    return bit_no == 0 ? 1'b0 : bit_no == 9 ? 1'b1 : c[bit_no-1];
  endfunction
  always @(posedge clk) begin
    if (!rst_n) begin
      m_q.delete();
      rep_t = -100000;
      m_cnt = 0;
      e_pulse = 1'b0;
    end else begin
      if (e_pulse) begin
        if (m_cnt < 255) m_cnt++;
        if (!e_busy) rep_t = cyc;
      end
      e_pulse = 1'b0;
      if (rx_valid) begin
        m_q.push_back(case_fold ? up(rx_byte) : rx_byte);
        if (m_q.size() > PL) void'(m_q.pop_front());
        if (m_q.size() == PL) begin
          e_pulse = 1'b1;
          for (int k = 0; k < PL; k++)
            if (m_q[k] != (case_fold ? up(PAT[k]) : PAT[k])) e_pulse = 1'b0;
        end
      end
    end
    cyc++;
    e_busy = cyc >= rep_t + 1 && cyc <= rep_t + 1 + RLEN;
    e_missed = e_pulse && e_busy;
    e_tx = tx_at(cyc - rep_t - 2);
    m_en = 1'b1;
  end
  always @(negedge clk)
    if (m_en) chk("model", {match_pulse, missed, busy, tx, match_count},
                  {e_pulse, e_missed, e_busy, e_tx, m_cnt[7:0]});

  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send0(input logic [7:0] b, input logic f);
    rx_byte = b;
    case_fold = f;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask
  task automatic sendb(input logic [7:0] b);
    b_byte = b;
    b_valid = 1'b1;
    tick();
    b_valid = 1'b0;
  endtask
  task automatic word0(input string w, input logic f);
    for (int i = 0; i < w.len(); i++) begin
      send0(w[i], f);
      if (i < w.len() - 1) repeat (3) tick();
    end
  endtask
  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 3000) begin
      tick();
      n++;
    end
    chk("idle_timeout", busy, 0);
  endtask

  typedef struct {logic [7:0] b; logic f; logic hit; logic [7:0] cnt;} vec_t;
  typedef struct {logic [7:0] b; logic hit_aa; logic hit_sat; logic [1:0] cnt;} bvec_t;
  vec_t vecs[15];
  bvec_t bv[29];

  initial begin
    string s, sb, al;
    int n, t0, bad;
    logic f;
    logic [7:0] c;
    s = "MARCOmarcomArCo";
    for (int i = 0; i < 15; i++)
      vecs[i] = '{s[i], i >= 10, i == 4 || i == 14, i < 4 ? 8'd0 : i < 14 ? 8'd1 : 8'd2};
    sb = "AAAAMARCOMARCOMARCOMARCOMARCO";
    for (int i = 0; i < 29; i++) begin
      n = i >= 4 ? (i - 4 + 1) / 5 : 0;
      bv[i] = '{sb[i], i >= 1 && i <= 3, i >= 4 && (i - 4) % 5 == 4, 2'(n > 3 ? 3 : n)};
    end

    repeat (3) tick();
    rst_n = 1'b1;
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_count", match_count, 0);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (match_pulse || missed) bad++;
    end
    chk("idle_pulses", bad, 0);

    for (int i = 0; i < 15; i++) begin
      send0(vecs[i].b, vecs[i].f);
      chk("vec_pulse", match_pulse, vecs[i].hit);
      if (vecs[i].hit) begin
        tick();
        chk("vec_busy_rise", busy, 1);
        wait_idle(n);
        chk("reply_len", n, RLEN + 1);
      end else repeat (3) tick();
      chk("vec_count", match_count, vecs[i].cnt);
    end

    word0("MARCO", 1'b0);
    t0 = cyc;
    chk("first_pulse", {match_pulse, missed}, 2'b10);
    repeat (21) tick();
    word0("MARCO", 1'b0);
    chk("missed_pulse", {match_pulse, missed}, 2'b11);
    wait_idle(n);
    chk("reply_end", cyc - t0, RLEN + 2);
    chk("missed_count", match_count, 4);

    word0("MARCO", 1'b0);
    t0 = cyc;
    while (cyc < t0 + 230) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_tx", tx, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_count", match_count, 0);
    word0("MARCO", 1'b0);
    chk("post_rst_pulse", match_pulse, 1);
    tick();
    wait_idle(n);
    chk("post_rst_len", n, RLEN + 1);
    chk("post_rst_count", match_count, 1);

    for (int i = 0; i < 29; i++) begin
      sendb(bv[i].b);
      chk("aa_pulse", mp1, bv[i].hit_aa);
      chk("sat_pulse", mp2, bv[i].hit_sat);
      tick();
      chk("sat_count", mc2, bv[i].cnt);
      repeat (2) tick();
    end

    al = "MARCOmarcoZ";
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        f = 1'($urandom_range(0, 1));
        for (int k = 0; k < PL; k++) begin
          c = PAT[k];
          if (f && $urandom_range(0, 1) == 1) c = c + 8'd32;
          send0(c, f);
          repeat ($urandom_range(0, 3)) tick();
        end
      end else begin
        send0(al[$urandom_range(0, 10)], 1'($urandom_range(0, 1)));
        repeat ($urandom_range(0, 3)) tick();
      end
    end
    tick();
    wait_idle(n);
    repeat (5) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
